// File: rtl/proc_mem_responder.sv
// proc_mem_responder
//   Memory-mapped responder on the processor's external bus. It decodes the
//   processor's registered ADDR/DOUT/W outputs and is the only driver of DIN.
//   It holds the instruction/data RAM, an LED register, a synchronized switch
//   port and a programmable down-counting timer with a sticky expiry flag.
//
//   Address map (ADDR[15:12]):
//     0x0 RAM (index ADDR[RAM_AW-1:0], higher bits alias)
//     0x1 LEDR          0x2 SW (read-only)
//     0x3 timer: ADDR[1:0] = 0 TCTRL {AUTO,EN}, 1 TLOAD, 2 TCOUNT (ro),
//                            3 TSTAT {FLAG}, write 1 to bit0 clears
//     others read 0, writes ignored
//
// Ports:
//   Clock  in   system clock, rising edge
//   Reset  in   synchronous active-high reset
//   ADDR   in   [15:0] word address
//   DOUT   in   [15:0] write data
//   W      in   write strobe
//   DIN    out  [15:0] combinational read data
//   SW     in   [SW_W-1:0] asynchronous switches
//   LEDR   out  [LED_W-1:0] LED register
//   TIRQ   out  timer expiry flag (level)
module proc_mem_responder #(
  parameter int RAM_AW   = 7,
  parameter int LED_W    = 10,
  parameter int SW_W     = 10,
  parameter int PRESCALE = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [15:0]       ADDR,
  input  logic [15:0]       DOUT,
  input  logic              W,
  output logic [15:0]       DIN,
  input  logic [SW_W-1:0]   SW,
  output logic [LED_W-1:0]  LEDR,
  output logic              TIRQ
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_RELOAD = PS_W'(PRESCALE - 1);

  logic [15:0]       mem [2**RAM_AW];
  logic [LED_W-1:0]  led_reg;
  logic [SW_W-1:0]   sw_meta_reg;
  logic [SW_W-1:0]   sw_sync_reg;
  logic              en_reg;
  logic              auto_reg;
  logic [15:0]       tload_reg;
  logic [15:0]       tcount_reg;
  logic              flag_reg;
  logic [PS_W-1:0]   presc_reg;

  logic [RAM_AW-1:0] ram_idx;
  logic              wr;
  logic              sel_ram, sel_led, sel_tmr;
  logic              wr_ctrl, wr_load, wr_stat;
  logic              tick, expire;
  logic [15:0]       rdata;

  assign ram_idx = ADDR[RAM_AW-1:0];
  // A write strobe during reset never reaches any target, RAM included.
  assign wr      = W && !Reset;
  assign sel_ram = (ADDR[15:12] == 4'h0);
  assign sel_led = (ADDR[15:12] == 4'h1);
  assign sel_tmr = (ADDR[15:12] == 4'h3);
  assign wr_ctrl = wr && sel_tmr && (ADDR[1:0] == 2'd0);
  assign wr_load = wr && sel_tmr && (ADDR[1:0] == 2'd1);
  assign wr_stat = wr && sel_tmr && (ADDR[1:0] == 2'd3);

  assign tick   = en_reg && (presc_reg == '0);
  assign expire = tick && (tcount_reg == 16'd0);

  // RAM has no reset; contents survive Reset.
  always_ff @(posedge Clock) begin
    if (wr && sel_ram) begin
      mem[ram_idx] <= DOUT;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      led_reg     <= '0;
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
      en_reg      <= 1'b0;
      auto_reg    <= 1'b0;
      tload_reg   <= 16'd0;
      tcount_reg  <= 16'd0;
      flag_reg    <= 1'b0;
      presc_reg   <= PS_RELOAD;
    end else begin
      sw_meta_reg <= SW;
      sw_sync_reg <= sw_meta_reg;

      if (wr && sel_led) begin
        led_reg <= DOUT[LED_W-1:0];
      end

      // Enabling through TCTRL restarts the prescale period.
      if (wr_ctrl && DOUT[0]) begin
        presc_reg <= PS_RELOAD;
      end else if (en_reg) begin
        presc_reg <= (presc_reg == '0) ? PS_RELOAD : presc_reg - 1'b1;
      end

      // Explicit TCTRL write overrides the one-shot auto-disable.
      if (wr_ctrl) begin
        en_reg   <= DOUT[0];
        auto_reg <= DOUT[1];
      end else if (expire && !auto_reg) begin
        en_reg <= 1'b0;
      end

      if (wr_load) begin
        tload_reg <= DOUT;
      end

      // TLOAD write beats any tick-driven change of the count.
      if (wr_load) begin
        tcount_reg <= DOUT;
      end else if (tick) begin
        if (tcount_reg != 16'd0) begin
          tcount_reg <= tcount_reg - 16'd1;
        end else if (auto_reg) begin
          tcount_reg <= tload_reg;
        end
      end

      // Expiry set takes priority over a same-cycle clear.
      if (expire) begin
        flag_reg <= 1'b1;
      end else if (wr_stat && DOUT[0]) begin
        flag_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = 16'h0000;
    case (ADDR[15:12])
      4'h0: rdata = mem[ram_idx];
      4'h1: rdata = 16'(led_reg);
      4'h2: rdata = 16'(sw_sync_reg);
      4'h3: begin
        case (ADDR[1:0])
          2'd0:    rdata = {14'd0, auto_reg, en_reg};
          2'd1:    rdata = tload_reg;
          2'd2:    rdata = tcount_reg;
          default: rdata = {15'd0, flag_reg};
        endcase
      end
      default: rdata = 16'h0000;
    endcase
  end

  assign DIN  = rdata;
  assign LEDR = led_reg;
  assign TIRQ = flag_reg;

  // Address bits between the RAM index and the region nibble are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ADDR[11:RAM_AW];

endmodule

// File: tb/tb_proc_mem_responder.sv
// Directed testbench for proc_mem_responder (default parameters).
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_proc_mem_responder;

  logic        Clock;
  logic        Reset;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] DIN;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic        TIRQ;

  int assert_count = 0;
  int fail_count   = 0;

  proc_mem_responder dut (
    .Clock (Clock),
    .Reset (Reset),
    .ADDR  (ADDR),
    .DOUT  (DOUT),
    .W     (W),
    .DIN   (DIN),
    .SW    (SW),
    .LEDR  (LEDR),
    .TIRQ  (TIRQ)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_value(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%04h", tag, got);
    end
  endtask

  // Called at a falling edge; the write commits on the following rising edge
  // and the task returns at the next falling edge.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    ADDR = a;
    DOUT = d;
    W    = 1'b1;
    @(negedge Clock);
    W    = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [15:0] a,
                            input logic [15:0] exp);
    ADDR = a;
    #1;
    check_value(tag, DIN, exp);
  endtask

  initial begin
    Reset = 1'b1;
    ADDR  = 16'h0000;
    DOUT  = 16'h0000;
    W     = 1'b0;
    SW    = 10'h000;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;

    // Reset state
    check_value("rst_ledr", 16'(LEDR), 16'h0000);
    check_value("rst_tirq", 16'(TIRQ), 16'h0000);
    read_check("rst_rd_led", 16'h1000, 16'h0000);
    read_check("rst_rd_sw", 16'h2000, 16'h0000);
    read_check("rst_rd_tctrl", 16'h3000, 16'h0000);
    @(negedge Clock);
    read_check("rst_rd_tcount", 16'h3002, 16'h0000);
    read_check("rst_rd_tstat", 16'h3003, 16'h0000);

    // RAM write/read with aliasing
    do_write(16'h0005, 16'h1234);
    do_write(16'h007F, 16'hBEEF);
    read_check("ram_05", 16'h0005, 16'h1234);
    read_check("ram_7f", 16'h007F, 16'hBEEF);
    read_check("ram_alias_85", 16'h0085, 16'h1234);
    @(negedge Clock);

    // LED
    do_write(16'h1000, 16'hFFFF);
    check_value("led_out", 16'(LEDR), 16'h03FF);
    read_check("led_rd", 16'h1000, 16'h03FF);
    read_check("led_rd_alias", 16'h1ABC, 16'h03FF);
    @(negedge Clock);

    // SW synchronizer: visible two edges after change
    SW = 10'h2A5;
    read_check("sw_edge0", 16'h2000, 16'h0000);
    @(negedge Clock);
    read_check("sw_edge1", 16'h2000, 16'h0000);
    @(negedge Clock);
    read_check("sw_edge2", 16'h2000, 16'h02A5);
    @(negedge Clock);
    do_write(16'h2000, 16'h1111);
    read_check("sw_wr_ignored", 16'h2000, 16'h02A5);
    check_value("sw_wr_led", 16'(LEDR), 16'h03FF);
    @(negedge Clock);

    // Unmapped
    read_check("unmapped_rd", 16'h5000, 16'h0000);
    @(negedge Clock);
    do_write(16'h5005, 16'hFFFF);
    read_check("unmapped_wr_rd", 16'h5005, 16'h0000);
    read_check("unmapped_wr_ram", 16'h0005, 16'h1234);
    @(negedge Clock);

    // Timer one-shot: TLOAD=3, EN
    do_write(16'h3001, 16'd3);
    read_check("os_tload", 16'h3001, 16'd3);
    @(negedge Clock);
    do_write(16'h3000, 16'h0001);
    read_check("os_cnt3", 16'h3002, 16'd3);
    @(negedge Clock);
    read_check("os_cnt2", 16'h3002, 16'd2);
    @(negedge Clock);
    read_check("os_cnt1", 16'h3002, 16'd1);
    @(negedge Clock);
    read_check("os_cnt0", 16'h3002, 16'd0);
    check_value("os_tirq_pre", 16'(TIRQ), 16'd0);
    @(negedge Clock);
    check_value("os_tirq", 16'(TIRQ), 16'd1);
    read_check("os_en_off", 16'h3000, 16'h0000);
    read_check("os_cnt_hold", 16'h3002, 16'd0);
    read_check("os_tstat", 16'h3003, 16'h0001);
    @(negedge Clock);
    check_value("os_tirq_sticky", 16'(TIRQ), 16'd1);
    read_check("os_cnt_hold2", 16'h3002, 16'd0);
    @(negedge Clock);
    do_write(16'h3003, 16'h0000);
    check_value("stat_wr0_noclr", 16'(TIRQ), 16'd1);
    do_write(16'h3003, 16'h0001);
    check_value("stat_clr", 16'(TIRQ), 16'd0);

    // Timer auto-reload: TLOAD=2, EN|AUTO
    do_write(16'h3001, 16'd2);
    do_write(16'h3000, 16'h0003);
    read_check("ar_cnt2", 16'h3002, 16'd2);
    @(negedge Clock);
    read_check("ar_cnt1", 16'h3002, 16'd1);
    @(negedge Clock);
    read_check("ar_cnt0", 16'h3002, 16'd0);
    @(negedge Clock);
    check_value("ar_tirq", 16'(TIRQ), 16'd1);
    read_check("ar_reload", 16'h3002, 16'd2);
    read_check("ar_en_on", 16'h3000, 16'h0003);
    // Clear on a non-expiry edge (count 2 -> 1)
    do_write(16'h3003, 16'h0001);
    check_value("ar_clr_tirq", 16'(TIRQ), 16'd0);
    read_check("ar_clr_cnt1", 16'h3002, 16'd1);
    @(negedge Clock);
    read_check("ar_cnt0_b", 16'h3002, 16'd0);
    check_value("ar_tirq_pre", 16'(TIRQ), 16'd0);
    // Clear on the expiry edge: set wins
    do_write(16'h3003, 16'h0001);
    check_value("ar_set_wins", 16'(TIRQ), 16'd1);
    read_check("ar_reload_b", 16'h3002, 16'd2);

    // Reset mid-operation with a RAM write pending
    do_write(16'h1000, 16'h0155);
    check_value("pre_rst_led", 16'(LEDR), 16'h0155);
    check_value("pre_rst_tirq", 16'(TIRQ), 16'd1);
    Reset = 1'b1;
    ADDR  = 16'h0005;
    DOUT  = 16'hAAAA;
    W     = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    W     = 1'b0;
    check_value("mid_rst_led", 16'(LEDR), 16'h0000);
    check_value("mid_rst_tirq", 16'(TIRQ), 16'd0);
    read_check("mid_rst_cnt", 16'h3002, 16'd0);
    read_check("mid_rst_ctrl", 16'h3000, 16'h0000);
    read_check("mid_rst_ram", 16'h0005, 16'h1234);
    @(negedge Clock);
    @(negedge Clock);
    @(negedge Clock);
    check_value("post_rst_tirq", 16'(TIRQ), 16'd0);
    read_check("post_rst_cnt", 16'h3002, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/proc_mem_responder.md
# proc_mem_responder

Memory-mapped responder on the processor's external bus: it decodes the processor's registered ADDR/DOUT/W outputs and drives the processor's DIN input. It holds the instruction/data RAM, an LED output register, a synchronized switch input port, and a programmable down-counting timer with a sticky expiry flag. It sits between the processor core and the board I/O and is the only driver of DIN.

## Interface

Parameters:
- RAM_AW, 7, RAM word-address width (2^RAM_AW 16-bit words)
- LED_W, 10, width of the LEDR register/output
- SW_W, 10, width of the SW input port
- PRESCALE, 1, timer tick period in Clock cycles (>= 1)

Ports:
- Clock  in  1  system clock, all state updates on its rising edge
- Reset  in  1  synchronous, active-high reset
- ADDR  in  16  word address from the processor (registered at the source)
- DOUT  in  16  write data from the processor (registered at the source)
- W  in  1  write strobe from the processor (registered at the source)
- DIN  out  16  read data to the processor
- SW  in  SW_W  asynchronous board switches
- LEDR  out  LED_W  LED register contents
- TIRQ  out  1  timer expiry flag (level)

## Operation

- Address map, decoded on ADDR[15:12]:
  - 0x0: RAM, index ADDR[RAM_AW-1:0]; remaining bits ignored (aliasing).
  - 0x1: LEDR (any low bits). Write: LEDR <= DOUT[LED_W-1:0]. Read: zero-extended LEDR.
  - 0x2: SW (any low bits). Read-only: zero-extended synchronized SW. Writes ignored.
  - 0x3: timer, selected by ADDR[1:0]: 0 TCTRL (bit0 EN, bit1 AUTO), 1 TLOAD (16-bit), 2 TCOUNT (read-only), 3 TSTAT (bit0 FLAG; writing 1 to DOUT[0] clears, writing 0 has no effect).
  - All others: reads return 0x0000, writes ignored.
- Reads are combinational: DIN = f(ADDR, current register/RAM state). No read side effects.
- A write occurs at the rising edge where W=1, to the target decoded from ADDR in that cycle.
- SW passes through a 2-flop synchronizer; reads see the second stage.
- Timer:
  - Prescaler counts PRESCALE-1 down to 0; tick when it is 0, then reloads. It runs only while EN=1. Writing TCTRL with EN=1 reloads the prescaler.
  - On a tick with EN=1: if TCOUNT != 0, TCOUNT decrements by 1. If TCOUNT == 0: FLAG <= 1; if AUTO=1, TCOUNT <= TLOAD; otherwise EN <= 0 and TCOUNT stays 0.
  - A write to TLOAD also loads TCOUNT. Same-cycle TLOAD write and tick: the write wins.
  - A same-cycle TCTRL write and expiry-clear of EN: the written value wins.
  - A same-cycle FLAG clear and expiry: set wins.
  - TIRQ = FLAG.
- 16-bit arithmetic, unsigned, no wrap below 0.

## Timing

- Reset (synchronous, one edge): LEDR=0, TCTRL=0, TLOAD=0, TCOUNT=0, FLAG=0, prescaler=PRESCALE-1, synchronizer flops=0. RAM contents are not cleared. W is ignored in any cycle with Reset=1, including RAM writes.
- Resulting reset-state outputs: LEDR=0, TIRQ=0. DIN stays combinational: 0 for LEDR, SW and timer addresses, 0 for unmapped addresses, and current (possibly undefined) contents for RAM.
- Read latency is 0 cycles relative to ADDR. The processor loads ADDR at edge N and samples DIN at edge N+1.
- Write-to-read: a value written at edge N is visible on DIN in the cycle after edge N, if ADDR is still on that location.
- SW-to-DIN latency: 2 edges.
- Timer, with PRESCALE=1 and EN set at edge N with TCOUNT=k: TCOUNT reaches 0 after edge N+k. FLAG and TIRQ rise after edge N+k+1.
- Reset asserted mid-countdown: the timer stops and clears at that edge. The next TIRQ requires a fresh TLOAD/TCTRL programming.

## Test plan

- RAM write/read: write 0x1234 to 0x0005 and 0xBEEF to 0x007F. Read 0x0005 gives 0x1234, 0x007F gives 0xBEEF, and alias 0x0085 gives 0x1234 (RAM_AW=7).
- LED/SW/unmapped:
  - Write 0xFFFF to 0x1000: LEDR=0x3FF, read 0x1000 gives 0x03FF.
  - SW=0x2A5: read 0x2000 gives 0x02A5 two edges later.
  - Write to 0x2000: no effect.
  - Read 0x5000 gives 0x0000.
- Timer one-shot: TLOAD=3, TCTRL=0x1. TCOUNT reads 3,2,1,0 on successive cycles. TIRQ=1 one cycle after reaching 0, EN then reads 0, and TCOUNT stays 0.
- Timer auto-reload with clear:
  - TLOAD=2, TCTRL=0x3: TIRQ sets, and TCOUNT reloads to 2.
  - Write 1 to 0x3003 on a non-expiry cycle: TIRQ=0.
  - Write 1 to 0x3003 on an expiry cycle: TIRQ stays 1.
- Reset mid-operation: with the timer running and LEDR=0x155, assert Reset for one cycle while W=1 to RAM 0x0005. Result: LEDR=0, TIRQ=0, TCOUNT=0, and RAM 0x0005 keeps its prior value.
